// File: rtl/vga_timing_receiver.sv
// rtl/vga_timing_receiver.sv - VGA sync/RGB332 receiver: recovers line/frame timing, locks, re-emits pixel coordinates
module vga_timing_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  r,
  input  logic [2:0]  g,
  input  logic [1:0]  b,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_rgb,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic        err
);
  localparam logic [10:0] HTOT  = 11'(H_TOTAL);
  localparam logic [10:0] HTMO  = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] HLO   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HHI   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] VTOT  = 11'(V_TOTAL);
  localparam logic [10:0] VLO   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] VHI   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  XOFF  = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  YOFF  = 10'(V_SYNC + V_BP);
  localparam logic [2:0]  LOCKN = 3'(LOCK_FRAMES);
  localparam logic [10:0] CMAX  = '1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state, state_nxt;
  logic        hs_prev, vs_prev, skip_line, skip_nxt;
  logic [10:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt, hcnt_p1, vcnt_p1;
  logic [2:0]  good_cnt, good_nxt;
  logic        hs_fall, vs_fall, line_bad, frame_ok, violation;
  logic        err_nxt, in_region, pv_nxt;
  logic [9:0]  x_nxt, y_nxt;

  always_comb begin
    hs_fall   = hs_prev & ~hsync;
    vs_fall   = hs_fall & vs_prev & ~vsync;
    hcnt_p1   = hcnt + 11'd1;
    vcnt_p1   = vcnt + 11'd1;
    hcnt_nxt  = hs_fall ? 11'd0 : ((hcnt == CMAX) ? hcnt : hcnt_p1);
    vcnt_nxt  = vs_fall ? 11'd0 : ((hs_fall && vcnt != CMAX) ? vcnt_p1 : vcnt);
    line_bad  = hs_fall & ~skip_line & (hcnt_p1 != HTOT);
    frame_ok  = vs_fall & (vcnt_p1 == VTOT);
    // Timeout fires once, on the sample that takes hcnt to 2*H_TOTAL.
    violation = line_bad | (vs_fall & ~frame_ok) | (~hs_fall & (hcnt == HTMO));

    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nxt = VERIFY;
          good_nxt  = 3'd0;
        end
      end
      VERIFY: begin
        if (violation) begin
          state_nxt = SEARCH;
        end else if (frame_ok) begin
          good_nxt = good_cnt + 3'd1;
          if (good_cnt + 3'd1 == LOCKN) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (violation) begin
          state_nxt = SEARCH;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase

    // The first line measured after falling back to SEARCH is partial, so it is not checked.
    if (state_nxt == SEARCH && state != SEARCH) skip_nxt = 1'b1;
    else if (hs_fall)                           skip_nxt = 1'b0;
    else                                        skip_nxt = skip_line;

    in_region = (hcnt_nxt >= HLO) && (hcnt_nxt < HHI) && (vcnt_nxt >= VLO) && (vcnt_nxt < VHI);
    pv_nxt    = (state_nxt == LOCKED) && in_region;
    x_nxt     = hcnt_nxt[9:0] - XOFF;
    y_nxt     = vcnt_nxt[9:0] - YOFF;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else if (pix_en) state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      skip_line   <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      line_len    <= '0;
      err         <= 1'b0;
    end else if (!pix_en) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      hs_prev     <= hsync;
      if (hs_fall) begin
        vs_prev  <= vsync;
        line_len <= hcnt_p1;
      end
      skip_line   <= skip_nxt;
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      good_cnt    <= good_nxt;
      locked      <= (state_nxt == LOCKED);
      pix_valid   <= pv_nxt;
      frame_start <= vs_fall;
      err         <= err_nxt;
      if (pv_nxt) begin
        pix_x   <= x_nxt;
        pix_y   <= y_nxt;
        pix_rgb <= {r, g, b};
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb/tb_vga_timing_receiver.sv - directed frame-level bench for vga_timing_receiver on a reduced raster
module tb_vga_timing_receiver;
  localparam int HT = 20, HS = 2, HB = 3, HA = 12;
  localparam int VT = 12, VS = 1, VB = 2, VA = 7;

  logic        clk = 1'b0;
  logic        rst, pix_en, hsync, vsync;
  logic [2:0]  r, g;
  logic [1:0]  b;
  logic        locked, pix_valid, frame_start, err;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_rgb;
  logic [10:0] line_len;

  always #5 clk = ~clk;

  vga_timing_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .locked(locked), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_start(frame_start),
    .line_len(line_len), .err(err)
  );

  int   n_vec = 0, n_err = 0;
  int   fs_c, err_c, pv_c, bad_c, spur_c = 0;
  int   fx, fy, lx, ly, len_at_err;
  logic lk0, lk_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic hs, input logic vs, input int x, input int y);
    logic [7:0] exp_rgb;
    exp_rgb = {x[2:0], y[2:0], x[4:3]};
    @(negedge clk);
    hsync = hs; vsync = vs; r = x[2:0]; g = y[2:0]; b = x[4:3]; pix_en = 1'b1;
    @(posedge clk); #1;
    if (frame_start) fs_c++;
    if (err) begin
      err_c++;
      len_at_err = int'(line_len);
    end
    if (pix_valid) begin
      if (pv_c == 0) begin fx = int'(pix_x); fy = int'(pix_y); end
      lx = int'(pix_x); ly = int'(pix_y);
      pv_c++;
      if (int'(pix_x) != x || int'(pix_y) != y || pix_rgb != exp_rgb) bad_c++;
    end
    @(negedge clk);
    pix_en = 1'b0;
    repeat (1 + $urandom_range(0, 2)) begin
      @(posedge clk); #1;
      if (frame_start || err || pix_valid) spur_c++;
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst = 1'b1; pix_en = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_flags", {locked, pix_valid, frame_start, err}, 0);
    check("rst_mid_len_x", {line_len, pix_x}, 0);
    check("rst_mid_y_rgb", {pix_y, pix_rgb}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame; short_line is one pixel short, long_line keeps hsync high for 2*HT samples.
  task automatic frame(input int nlines, input int short_line, input int long_line, input int rst_line);
    int len;
    fs_c = 0; err_c = 0; pv_c = 0; bad_c = 0; fx = -1; fy = -1; lx = -1; ly = -1; len_at_err = -1;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : (l == long_line) ? 2 * HT : HT;
      for (int p = 0; p < len; p++) begin
        if (l == rst_line && p == 8) begin
          mid_reset();
          return;
        end
        sample((l == long_line) ? 1'b1 : (p >= HS), (l >= VS), p - (HS + HB), l - (VS + VB));
        if (l == 0 && p == 0) lk0 = locked;
      end
    end
    lk_end = locked;
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; r = '0; g = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {locked, pix_valid, frame_start, err}, 0);
    check("reset_len_x", {line_len, pix_x}, 0);
    check("reset_y_rgb", {pix_y, pix_rgb}, 0);
    @(negedge clk);
    rst = 1'b0;

    frame(VT, -1, -1, -1);
    check("f0_fs", fs_c, 1);       check("f0_err", err_c, 0);
    check("f0_pv", pv_c, 0);       check("f0_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f1_lock", lk_end, 0);   check("f1_line_len", line_len, HT);
    frame(VT, -1, -1, -1);
    check("f2_lock0", lk0, 1);     check("f2_pv", pv_c, HA * VA);
    check("f2_first_x", fx, 0);    check("f2_first_y", fy, 0);
    check("f2_last_x", lx, HA - 1); check("f2_last_y", ly, VA - 1);
    check("f2_rgb_bad", bad_c, 0); check("f2_err", err_c, 0);

    frame(VT, 5, -1, -1);
    check("short_err", err_c, 1);  check("short_len", len_at_err, HT - 1);
    check("short_pv", pv_c, 3 * HA); check("short_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f4_lock", lk_end, 0);   check("f4_err", err_c, 0);
    frame(VT, -1, -1, -1);
    check("f5_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f6_lock0", lk0, 1);     check("f6_pv", pv_c, HA * VA);
    check("f6_rgb_bad", bad_c, 0);

    frame(VT, -1, 4, -1);
    check("tmo_err", err_c, 1);    check("tmo_pv", pv_c, HA);
    check("tmo_lock", lk_end, 0);
    frame(VT - 1, -1, -1, -1);
    check("f8_err", err_c, 0);     check("f8_pv", pv_c, 0);
    check("f8_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f9_fs", fs_c, 1);       check("f9_err", err_c, 0);
    check("f9_lock", lk_end, 0);   check("f9_pv", pv_c, 0);
    frame(VT, -1, -1, -1);
    check("f10_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f11_lock0", lk0, 0);    check("f11_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f12_lock0", lk0, 1);    check("f12_pv", pv_c, HA * VA);

    frame(VT, -1, -1, 4);
    check("f13_pv_before_rst", pv_c, HA + 3);
    frame(VT, -1, -1, -1);
    check("f14_fs", fs_c, 1);      check("f14_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f15_lock", lk_end, 0);
    frame(VT, -1, -1, -1);
    check("f16_lock0", lk0, 1);    check("f16_pv", pv_c, HA * VA);
    check("f16_rgb_bad", bad_c, 0);
    check("gap_spurious", spur_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
